// File: rtl/lfsr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_pkg
// Description : Shared types and constants for the Fibonacci LFSR pattern
//               generator and its receive-side checker.
// Revision    : 1.0 - initial release
// ============================================================================
package lfsr_pkg;

  // Checker synchronisation state
  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } lfsr_chk_state_t;

  // Default 8-bit tap mask (bits 7,5,4,3), shared with the generator
  localparam logic [7:0] LFSR_TAPS_8 = 8'b10111000;

endpackage : lfsr_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Saturating up-counter with synchronous clear. Clear has
//               priority over increment. Synchronous active-low reset.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  // Count up to all-ones and hold; clear overrides a coincident increment
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule : sat_counter
`default_nettype wire

// File: rtl/lfsr_checker.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_checker
// Description : Serial receive-side checker for the Fibonacci LFSR pattern
//               generator. Self-synchronises to the incoming stream, then
//               flywheels on its own prediction and flags mismatching bits.
//               Optional error/bit counters are built when the macro
//               LFSR_CHK_COUNTERS_EN is defined; otherwise they read 0.
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int                LENGTH   = 8,
  parameter logic [LENGTH-1:0] TAPS     = LENGTH'(LFSR_TAPS_8),
  parameter int                LOCK_CNT = 16,
  parameter int                LOSS_WIN = 64,
  parameter int                LOSS_ERR = 4,
  parameter int                CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] bit_count
);

  localparam int FILL_W = $clog2(LENGTH + 1);
  localparam int GOOD_W = $clog2(LOCK_CNT + 1);
  localparam int WIN_W  = $clog2(LOSS_WIN + 1);
  localparam int WERR_W = $clog2(LOSS_ERR + 1);

  lfsr_chk_state_t    state, state_n;
  logic [LENGTH-1:0]  shreg, shreg_n;
  logic [FILL_W-1:0]  fill_cnt, fill_cnt_n;
  logic [GOOD_W-1:0]  good_cnt, good_cnt_n;
  logic [WIN_W-1:0]   win_cnt, win_cnt_n;
  logic [WERR_W-1:0]  werr_cnt, werr_cnt_n;
  logic               err_pulse_n;
  logic               err_inc;
  logic               bit_inc;

  logic               expected;
  logic               mismatch;
  logic [WERR_W-1:0]  werr_sum;

  // Prediction is the feedback the generator would produce from this state
  assign expected = ^(shreg & TAPS);
  assign mismatch = bit_in ^ expected;
  assign werr_sum = werr_cnt + WERR_W'(mismatch);

  assign locked   = (state == LOCKED);

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= HUNT;
      shreg     <= '0;
      fill_cnt  <= '0;
      good_cnt  <= '0;
      win_cnt   <= '0;
      werr_cnt  <= '0;
      err_pulse <= 1'b0;
    end else begin
      state     <= state_n;
      shreg     <= shreg_n;
      fill_cnt  <= fill_cnt_n;
      good_cnt  <= good_cnt_n;
      win_cnt   <= win_cnt_n;
      werr_cnt  <= werr_cnt_n;
      err_pulse <= err_pulse_n;
    end
  end

  // Next-state logic: fill, verify with self-sync, then flywheel while locked
  always_comb begin
    state_n     = state;
    shreg_n     = shreg;
    fill_cnt_n  = fill_cnt;
    good_cnt_n  = good_cnt;
    win_cnt_n   = win_cnt;
    werr_cnt_n  = werr_cnt;
    err_pulse_n = 1'b0;
    err_inc     = 1'b0;
    bit_inc     = 1'b0;

    if (bit_valid) begin
      unique case (state)
        HUNT: begin
          shreg_n = {shreg[LENGTH-2:0], bit_in};
          if (fill_cnt == FILL_W'(LENGTH - 1)) begin
            fill_cnt_n = '0;
            good_cnt_n = '0;
            state_n    = VERIFY;
          end else begin
            fill_cnt_n = fill_cnt + FILL_W'(1);
          end
        end

        VERIFY: begin
          shreg_n = {shreg[LENGTH-2:0], bit_in};
          // An all-zero register predicts zeros forever; never credit it
          if (!mismatch && (|shreg)) begin
            if (good_cnt == GOOD_W'(LOCK_CNT - 1)) begin
              good_cnt_n = '0;
              win_cnt_n  = '0;
              werr_cnt_n = '0;
              state_n    = LOCKED;
            end else begin
              good_cnt_n = good_cnt + GOOD_W'(1);
            end
          end else begin
            good_cnt_n = '0;
          end
        end

        LOCKED: begin
          // Flywheel: a corrupted channel bit never enters the predictor
          shreg_n     = {shreg[LENGTH-2:0], expected};
          bit_inc     = 1'b1;
          err_pulse_n = mismatch;
          err_inc     = mismatch;
          if (werr_sum == WERR_W'(LOSS_ERR)) begin
            fill_cnt_n = '0;
            win_cnt_n  = '0;
            werr_cnt_n = '0;
            state_n    = HUNT;
          end else if (win_cnt == WIN_W'(LOSS_WIN - 1)) begin
            win_cnt_n  = '0;
            werr_cnt_n = '0;
          end else begin
            win_cnt_n  = win_cnt + WIN_W'(1);
            werr_cnt_n = werr_sum;
          end
        end

        default: begin
          state_n = HUNT;
        end
      endcase
    end
  end

`ifdef LFSR_CHK_COUNTERS_EN
  sat_counter #(
    .CNT_W (CNT_W)
  ) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (err_inc),
    .clr   (clear),
    .count (err_count)
  );

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_bit_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (bit_inc),
    .clr   (clear),
    .count (bit_count)
  );
`else
  logic unused_cnt_ctrl;
  assign unused_cnt_ctrl = clear | err_inc | bit_inc;
  assign err_count       = '0;
  assign bit_count       = '0;
`endif

endmodule : lfsr_checker
`default_nettype wire

// File: tb/tb_lfsr_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_lfsr_checker
// Description : Directed self-checking bench for lfsr_checker. A default
//               instance and a CNT_W=4 instance share one stimulus stream.
//               Counter expectations read 0 unless LFSR_CHK_COUNTERS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lfsr_checker;
  import lfsr_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        bit_in;
  logic        bit_valid;
  logic        clear;

  logic        locked;
  logic        err_pulse;
  logic [15:0] err_count;
  logic [15:0] bit_count;

  logic        locked4;
  logic        err_pulse4;
  logic [3:0]  err_count4;
  logic [3:0]  bit_count4;

  int          checks   = 0;
  int          failures = 0;
  int          pulses   = 0;
  logic [7:0]  gen;

  always #5 clk = ~clk;

  lfsr_checker dut (
    .clk       (clk),
    .rst       (rst),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .clear     (clear),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_count (err_count),
    .bit_count (bit_count)
  );

  lfsr_checker #(
    .CNT_W (4)
  ) dut4 (
    .clk       (clk),
    .rst       (rst),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .clear     (clear),
    .locked    (locked4),
    .err_pulse (err_pulse4),
    .err_count (err_count4),
    .bit_count (bit_count4)
  );

  // Expected counter value given whether counters are built
  function automatic int cexp(input int v, input int maxv);
`ifdef LFSR_CHK_COUNTERS_EN
    return (v > maxv) ? maxv : v;
`else
    return 0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock step; outputs sampled 1 time unit after the rising edge
  task automatic send(input logic b, input logic v);
    bit_in    = b;
    bit_valid = v;
    @(posedge clk);
    #1;
    if (err_pulse) pulses++;
  endtask

  // Advance the generator model and transmit its feedback bit
  task automatic send_gen(input logic flip);
    logic fb;
    fb  = ^(gen & LFSR_TAPS_8);
    gen = {gen[6:0], fb};
    send(fb ^ flip, 1'b1);
  endtask

  task automatic do_reset();
    rst       = 1'b0;
    bit_in    = 1'b0;
    bit_valid = 1'b0;
    clear     = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic clear_pulse();
    clear = 1'b1;
    send(1'b0, 1'b0);
    clear = 1'b0;
  endtask

  initial begin
    // ---------------- reset state
    do_reset();
    chk("rst_locked",    locked,     0);
    chk("rst_err_pulse", err_pulse,  0);
    chk("rst_err_count", err_count,  0);
    chk("rst_bit_count", bit_count,  0);
    chk("rst_err_cnt4",  err_count4, 0);
    chk("rst_bit_cnt4",  bit_count4, 0);

    // ---------------- clean stream, seed 8'h01, 1000 bits
    gen    = 8'h01;
    pulses = 0;
    for (int n = 1; n <= 1000; n++) begin
      send_gen(1'b0);
      if (n == 23) chk("lock_bit23", locked, 0);
      if (n == 24) chk("lock_bit24", locked, 1);
    end
    chk("clean_pulses",   pulses,     0);
    chk("clean_locked",   locked,     1);
    chk("clean_errcnt",   err_count,  0);
    chk("clean_bitcnt",   bit_count,  cexp(976, 65535));
    chk("clean_bitcnt4",  bit_count4, cexp(976, 15));

    // ---------------- single flip at stream bit 100
    do_reset();
    gen    = 8'h01;
    pulses = 0;
    for (int n = 1; n <= 150; n++) begin
      send_gen(n == 100);
      if (n == 100) chk("flip_pulse_hi", err_pulse, 1);
      if (n == 101) chk("flip_pulse_lo", err_pulse, 0);
    end
    chk("flip_pulses", pulses,    1);
    chk("flip_errcnt", err_count, cexp(1, 65535));
    chk("flip_locked", locked,    1);

    // ---------------- 4 flips 5 bits apart in one window -> loss, re-lock
    clear_pulse();
    chk("clr_errcnt", err_count, 0);
    chk("clr_bitcnt", bit_count, 0);
    chk("clr_locked", locked,    1);
    pulses = 0;
    for (int n = 151; n <= 199; n++) begin
      send_gen((n == 160) || (n == 165) || (n == 170) || (n == 175));
      if (n == 170) chk("loss_3rd_locked", locked, 1);
      if (n == 175) begin
        chk("loss_4th_locked", locked,    0);
        chk("loss_4th_pulse",  err_pulse, 1);
        chk("loss_errcnt",     err_count, cexp(4, 65535));
        chk("loss_bitcnt",     bit_count, cexp(25, 65535));
      end
      if (n == 198) chk("relock_pre",  locked, 0);
      if (n == 199) chk("relock_rise", locked, 1);
    end
    chk("loss_pulses", pulses, 4);

    // ---------------- all-zero stream never locks
    do_reset();
    pulses = 0;
    begin
      int lk;
      lk = 0;
      for (int n = 0; n < 200; n++) begin
        send(1'b0, 1'b1);
        if (locked) lk++;
      end
      chk("zero_locked_cycles", lk, 0);
    end
    chk("zero_errcnt", err_count, 0);
    chk("zero_pulses", pulses,    0);

    // ---------------- mid-stream reset, then re-lock
    do_reset();
    gen = 8'h01;
    for (int n = 1; n <= 30; n++) send_gen(1'b0);
    chk("pre_rst_locked", locked,    1);
    chk("pre_rst_bitcnt", bit_count, cexp(6, 65535));
    rst = 1'b0;
    send(1'b1, 1'b1);
    rst = 1'b1;
    chk("mid_rst_locked", locked,    0);
    chk("mid_rst_pulse",  err_pulse, 0);
    chk("mid_rst_errcnt", err_count, 0);
    chk("mid_rst_bitcnt", bit_count, 0);
    for (int v = 1; v <= 24; v++) begin
      send_gen(1'b0);
      if (v == 23) chk("rst_relock_pre",  locked, 0);
      if (v == 24) chk("rst_relock_rise", locked, 1);
    end

    // ---------------- 50% duty bit_valid: lock latency counted in valid bits
    do_reset();
    pulses = 0;
    for (int v = 1; v <= 25; v++) begin
      send_gen(1'b0);
      if (v == 24) chk("duty_lock_rise", locked, 1);
      send(1'b1, 1'b0);
      if (v == 23) chk("duty_gap_locked", locked, 0);
      if (v == 24) chk("duty_gap_bitcnt", bit_count, 0);
    end
    chk("duty_bitcnt", bit_count, cexp(1, 65535));
    chk("duty_pulses", pulses,    0);

    // ---------------- 20 errors in separate windows: CNT_W=4 saturates
    clear_pulse();
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      send_gen(1'b1);
      for (int j = 0; j < 63; j++) send_gen(1'b0);
    end
    chk("sat_locked",  locked,     1);
    chk("sat_pulses",  pulses,     20);
    chk("sat_errcnt",  err_count,  cexp(20, 65535));
    chk("sat_errcnt4", err_count4, cexp(20, 15));

    // Clear coincident with an error: clear wins
    clear = 1'b1;
    send_gen(1'b1);
    clear = 1'b0;
    chk("clr_err_pulse",  err_pulse,  1);
    chk("clr_err_errcnt", err_count,  0);
    chk("clr_err_cnt4",   err_count4, 0);
    for (int j = 0; j < 5; j++) send_gen(1'b0);
    send_gen(1'b1);
    chk("post_clr_cnt4",   err_count4, cexp(1, 15));
    chk("post_clr_locked", locked,     1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_lfsr_checker
`default_nettype wire

// File: doc/lfsr_checker.md
# lfsr_checker

Serial receive-side checker for the team's Fibonacci LFSR pattern generator. It consumes one bit per valid cycle, self-synchronises a local copy of the LFSR register to the incoming stream, and then flags every bit that differs from the predicted sequence. It sits at the far end of a link or loopback path and drives lock status and error/bit counters for bring-up and BER measurement.

## Interface
- LENGTH, default 8: LFSR register width; must be ≥ 2.
- TAPS, default 8'b10111000 (LENGTH bits): tap mask, bits 7,5,4,3; must equal the generator's mask.
- LOCK_CNT, default 16: consecutive correct predictions required to declare lock.
- LOSS_WIN, default 64: lock-loss observation window, in valid bits.
- LOSS_ERR, default 4: errors within one window that drop lock.
- CNT_W, default 16: width of the error and bit counters.
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-low reset.
- bit_in  in  1  received serial bit.
- bit_valid  in  1  bit_in is sampled only when high.
- clear  in  1  synchronous clear of err_count and bit_count; lock state is kept.
- locked  out  1  high while in LOCKED.
- err_pulse  out  1  one-cycle pulse per mismatching bit while LOCKED.
- err_count  out  CNT_W  saturating count of err_pulse events.
- bit_count  out  CNT_W  saturating count of valid bits checked while LOCKED.

## Operation
- Stream definition: the generator transmits its feedback bit each step, i.e. the new state[0]. The checker keeps a LENGTH-bit shift register `shreg`. Each valid bit shifts it up one place: the incoming or selected bit enters at bit 0 and bit LENGTH-1 is dropped. The predicted bit is expected = ^(shreg & TAPS).
- States: HUNT, VERIFY, LOCKED.
- HUNT: on each valid bit, shift bit_in into shreg and increment the fill counter. After LENGTH valid bits, go to VERIFY and reset the good counter to 0.
- VERIFY: on each valid bit, compare bit_in with expected, then shift bit_in into shreg (self-synchronising).
  - If the bit matches and shreg is not all-zero, increment the good counter.
  - Otherwise, reset the good counter to 0.
  - When the good counter reaches LOCK_CNT, go to LOCKED and reset the window and window-error counters.
- LOCKED (flywheel): on each valid bit, shift expected into shreg instead of bit_in, so a single channel error is counted once.
  - A mismatch raises err_pulse and increments the window-error counter.
  - The window counter wraps at LOSS_WIN, and the window-error counter resets to 0 on that wrap.
  - When the window-error counter reaches LOSS_ERR, go to HUNT with the fill counter at 0. The error that triggered the drop is still reported.
- All-zero guard: an all-zero stream must never lock, because the all-zero state is a lock-up state of the generator.
- Counters:
  - err_count and bit_count increment only while LOCKED and only on valid bits.
  - Both saturate at 2^CNT_W−1.
  - If clear and an increment occur in the same cycle, clear wins and the counter becomes 0.
- bit_valid low: no state, shreg or counter changes; err_pulse is 0.
- Reset, including mid-stream: go to HUNT, set shreg and all internal counters to 0, and set every output to 0.

## Timing
- All outputs are registered.
- err_pulse is high in the cycle after the clock edge that samples the erroneous bit. err_count updates on that same edge.
- Lock latency: locked rises on the edge that samples valid bit number LENGTH+LOCK_CNT after reset on a clean stream (24 bits with the defaults).
- Loss latency: locked falls on the edge that samples the LOSS_ERR-th error within a window.
- Throughput: one bit per cycle. Gaps in bit_valid only stretch the timing.

## Configuration
- LFSR_CHK_COUNTERS_EN defined: err_count and bit_count are implemented as described above.
- Undefined: both counter outputs are tied to 0, and clear has no effect. Lock logic and err_pulse are unchanged.

## Structure
- Shared package lfsr_pkg holds:
  - the state enum lfsr_chk_state_t (HUNT, VERIFY, LOCKED);
  - the default tap constant LFSR_TAPS_8 = 8'b10111000, shared with the generator.
- One sub-module, sat_counter (parameter CNT_W; inputs inc and clr), is instantiated twice, for err_count and bit_count.

## Test plan
- Generator model seeded with 8'h01 driving a continuous valid stream: locked rises after the 24th bit, and err_pulse stays 0 for 1000 bits.
- Single bit flip at stream bit 100 while locked: exactly one err_pulse, err_count = 1, locked stays 1.
- 4 flips spaced 5 bits apart within one window: locked falls on the 4th flip, err_count = 4, then lock is regained 24 clean bits later.
- All-zero input for 200 bits: locked stays 0 and err_count stays 0.
- Apply rst low for 1 cycle while locked with bit_valid toggling: all outputs are 0 on the next cycle, and re-lock occurs after 24 valid bits. Then run a bit_valid 50% duty stream and check that the lock bit count is unchanged.
- CNT_W = 4 with 20 injected errors spread over separate windows: err_count saturates at 15; clear asserted together with an error sets err_count to 0.
